// File: rtl/usr_pkg.sv
// usr_pkg -- shared definitions for the universal shift register.
// Holds the 2-bit mode encoding and small helpers used by the top module.
// Optional feature macro used by the design: USR_ROTATE_EN (rotate port).
package usr_pkg;

   // Operating modes selected by the 2-bit mode input
   typedef enum logic [1:0] {
      USR_HOLD = 2'b00,
      USR_SHR  = 2'b01,
      USR_SHL  = 2'b10,
      USR_LOAD = 2'b11
   } usr_mode_e;

   // Raw encodings, for code that works on plain 2-bit vectors
   localparam logic [1:0] USR_HOLD_C = 2'b00;
   localparam logic [1:0] USR_SHR_C  = 2'b01;
   localparam logic [1:0] USR_SHL_C  = 2'b10;
   localparam logic [1:0] USR_LOAD_C = 2'b11;

   // True for the two modes that move data and advance the shift counter
   function automatic logic usr_is_shift(input usr_mode_e m);
      return (m == USR_SHR) || (m == USR_SHL);
   endfunction

endpackage : usr_pkg

// File: rtl/usr_shift_counter.sv
// usr_shift_counter -- saturating up-counter with synchronous clear.
// Counts inc pulses from 0 up to MAX and then sticks; full flags count == MAX.
// clear has priority over inc. rst is asynchronous, active-high.
module usr_shift_counter #(
   parameter int MAX = 8,
   localparam int CW = $clog2(MAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          full
);

   localparam logic [CW-1:0] MAX_C = CW'(MAX);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          full_w;

   assign full_w = (count_q == MAX_C);

   // Next count: clear wins, otherwise step until saturation
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && !full_w) begin
         count_d = count_q + CW'(1);
      end
   end

   // Counter register, cleared immediately by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign full  = full_w;

endmodule : usr_shift_counter

// File: rtl/universal_shift_register.sv
// universal_shift_register -- hold / shift right / shift left / parallel load.
// The datapath (register contents and serial output) lives here; the
// saturating shift counter is delegated to usr_shift_counter.
// Optional feature: define USR_ROTATE_EN to add the rotate input, which feeds
// the shifted-out bit back into the vacated end instead of serialIn.
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] parallelIn,
   input  logic             serialIn,
`ifdef USR_ROTATE_EN
   input  logic             rotate,
`endif
   output logic             serialOut,
   output logic [WIDTH-1:0] state,
   output logic [CW-1:0]    shiftCount,
   output logic             done
);

   usr_mode_e        mode_w;
   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic             sout_q;
   logic             sout_d;
   logic             fill_shr_w;
   logic             fill_shl_w;
   logic             cnt_clear_w;
   logic             cnt_inc_w;
   logic             cnt_full_w;

   assign mode_w = usr_mode_e'(mode);

   // Bit entering the vacated end: serialIn, or the outgoing bit when rotating
`ifdef USR_ROTATE_EN
   assign fill_shr_w = rotate ? state_q[0]       : serialIn;
   assign fill_shl_w = rotate ? state_q[WIDTH-1] : serialIn;
`else
   assign fill_shr_w = serialIn;
   assign fill_shl_w = serialIn;
`endif

   // Next register contents and serial output for the selected mode
   always_comb begin
      state_d = state_q;
      sout_d  = sout_q;
      if (enable) begin
         case (mode_w)
            USR_SHR: begin
               state_d = {fill_shr_w, state_q[WIDTH-1:1]};
               sout_d  = state_q[0];
            end
            USR_SHL: begin
               state_d = {state_q[WIDTH-2:0], fill_shl_w};
               sout_d  = state_q[WIDTH-1];
            end
            USR_LOAD: begin
               state_d = parallelIn;
               sout_d  = 1'b0;
            end
            default: begin
               state_d = state_q;
               sout_d  = sout_q;
            end
         endcase
      end
   end

   // Data and serial-out registers; reset clears them immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= '0;
         sout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sout_q  <= sout_d;
      end
   end

   // Counter control: loads restart the count, shifts advance it
   always_comb begin
      cnt_clear_w = enable && (mode_w == USR_LOAD);
      cnt_inc_w   = enable && usr_is_shift(mode_w);
   end

   usr_shift_counter #(
      .MAX (WIDTH)
   ) u_shift_counter (
      .clk   (clk),
      .rst   (reset),
      .clear (cnt_clear_w),
      .inc   (cnt_inc_w),
      .count (shiftCount),
      .full  (cnt_full_w)
   );

   assign state     = state_q;
   assign serialOut = sout_q;
   assign done      = cnt_full_w;

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
// Testbench for universal_shift_register (WIDTH = 8).
// Directed scenarios followed by randomized operations, all compared against
// an arithmetic reference model of the register, serial output and counter.
module tb_universal_shift_register;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);
   localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;
`ifdef USR_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          enable;
   logic [1:0]    mode;
   logic [W-1:0]  parallelIn;
   logic          serialIn;
   logic          rotate;
   logic          serialOut;
   logic [W-1:0]  state;
   logic [CW-1:0] shiftCount;
   logic          done;

   int checks = 0;
   int errors = 0;

   // reference model
   logic [63:0] m_state;
   logic        m_out;
   int          m_cnt;

   universal_shift_register #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .mode       (mode),
      .parallelIn (parallelIn),
      .serialIn   (serialIn),
`ifdef USR_ROTATE_EN
      .rotate     (rotate),
`endif
      .serialOut  (serialOut),
      .state      (state),
      .shiftCount (shiftCount),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 64'd0;
      m_out   = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic model_apply(input bit en, input logic [1:0] md, input logic [W-1:0] pin,
                              input bit sin, input bit rot);
      logic [63:0] outbit;
      logic [63:0] fill;
      if (!en) return;
      case (md)
         2'd1: begin
            outbit  = m_state & 64'd1;
            fill    = (ROT_EN && rot) ? outbit : {63'd0, sin};
            m_state = (m_state >> 1) | (fill << (W - 1));
            m_out   = outbit[0];
            m_cnt   = (m_cnt + 1 > W) ? W : m_cnt + 1;
         end
         2'd2: begin
            outbit  = (m_state >> (W - 1)) & 64'd1;
            fill    = (ROT_EN && rot) ? outbit : {63'd0, sin};
            m_state = ((m_state << 1) | fill) & MASK;
            m_out   = outbit[0];
            m_cnt   = (m_cnt + 1 > W) ? W : m_cnt + 1;
         end
         2'd3: begin
            m_state = {56'd0, pin} & MASK;
            m_out   = 1'b0;
            m_cnt   = 0;
         end
         default: ;
      endcase
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"}, {56'd0, state}, m_state);
      chk({tag, ".serialOut"}, {63'd0, serialOut}, {63'd0, m_out});
      chk({tag, ".shiftCount"}, 64'(shiftCount), 64'(m_cnt));
      chk({tag, ".done"}, {63'd0, done}, {63'd0, (m_cnt == W)});
   endtask

   // Drive one operation, let one edge happen, update the model, compare
   task automatic step(input string tag, input bit en, input logic [1:0] md,
                       input logic [W-1:0] pin, input bit sin, input bit rot);
      enable     = en;
      mode       = md;
      parallelIn = pin;
      serialIn   = sin;
      rotate     = rot;
      @(posedge clk);
      #1;
      model_apply(en, md, pin, sin, rot);
      check_all(tag);
   endtask

   logic [7:0] exp_sout_seq;
   logic [7:0] exp_left_seq [3];

   initial begin
      // Reset with arbitrary inputs, checked before any clock edge
      reset      = 1'b1;
      enable     = 1'($urandom);
      mode       = 2'($urandom);
      parallelIn = W'($urandom);
      serialIn   = 1'($urandom);
      rotate     = 1'($urandom);
      model_reset();
      #2;
      chk("rst.state", {56'd0, state}, 64'h00);
      chk("rst.serialOut", {63'd0, serialOut}, 64'd0);
      chk("rst.shiftCount", 64'(shiftCount), 64'd0);
      chk("rst.done", {63'd0, done}, 64'd0);
      @(posedge clk);
      #1;
      check_all("rst_edge");
      @(negedge clk);
      reset = 1'b0;

      // Load 0x09, eight right shifts, then two more past saturation
      exp_sout_seq = 8'b0000_1001; // bit i = serialOut after shift i
      step("ld09", 1, 2'b11, 8'h09, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step("shr", 1, 2'b01, 8'h00, 0, 0);
         chk("shr.sout_seq", {63'd0, serialOut}, {63'd0, exp_sout_seq[i]});
      end
      chk("shr8.state", {56'd0, state}, 64'h00);
      chk("shr8.done", {63'd0, done}, 64'd1);
      step("shr_sat", 1, 2'b01, 8'h00, 0, 0);
      step("shr_sat", 1, 2'b01, 8'h00, 0, 0);
      chk("sat.count", 64'(shiftCount), 64'd8);

      // Load 0x1C then three left shifts with serialIn=1
      exp_left_seq[0] = 8'h39;
      exp_left_seq[1] = 8'h73;
      exp_left_seq[2] = 8'hE7;
      step("ld1c", 1, 2'b11, 8'h1C, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step("shl", 1, 2'b10, 8'h00, 1, 0);
         chk("shl.state", {56'd0, state}, {56'd0, exp_left_seq[i]});
         chk("shl.sout", {63'd0, serialOut}, 64'd0);
      end
      chk("shl.count", 64'(shiftCount), 64'd3);
      chk("shl.done", {63'd0, done}, 64'd0);

      // Enable low holds everything regardless of mode
      step("ld5a", 1, 2'b11, 8'h5A, 0, 0);
      for (int i = 0; i < 5; i++) step("en0", 0, 2'b01, 8'hFF, 1, 0);
      chk("en0.state", {56'd0, state}, 64'h5A);
      chk("en0.count", 64'(shiftCount), 64'd0);
      step("en1", 1, 2'b01, 8'h00, 0, 0);
      chk("en1.state", {56'd0, state}, 64'h2D);
      chk("en1.sout", {63'd0, serialOut}, 64'd0);

      // Reset pulsed between edges in the middle of a shift sequence
      step("ldff", 1, 2'b11, 8'hFF, 0, 0);
      for (int i = 0; i < 4; i++) step("shr4", 1, 2'b01, 8'h00, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      chk("midrst.state", {56'd0, state}, 64'h00);
      chk("midrst.count", 64'(shiftCount), 64'd0);
      chk("midrst.done", {63'd0, done}, 64'd0);
      #1;
      reset = 1'b0;
      step("ld1c_post", 1, 2'b11, 8'h1C, 0, 0);
      chk("post.state", {56'd0, state}, 64'h1C);

`ifdef USR_ROTATE_EN
      // Rotation feeds the outgoing bit back in
      step("ld81", 1, 2'b11, 8'h81, 0, 0);
      step("rotr", 1, 2'b01, 8'h00, 0, 1);
      chk("rotr.state", {56'd0, state}, 64'hC0);
      chk("rotr.sout", {63'd0, serialOut}, 64'd1);
      step("rotl", 1, 2'b10, 8'h00, 0, 1);
      chk("rotl.state", {56'd0, state}, 64'h81);
      chk("rotl.sout", {63'd0, serialOut}, 64'd1);
`endif

      // Randomized operations, with occasional asynchronous reset pulses
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            @(negedge clk);
            reset = 1'b1;
            #1;
            model_reset();
            check_all("rnd_rst");
            #1;
            reset = 1'b0;
         end
         step("rnd", ($urandom_range(0, 7) != 0), 2'($urandom), W'($urandom),
              1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_universal_shift_register
